// File: rtl/tv80_tb_pkg.sv
// Shared types for the tv80 bus responder: FSM state encoding and the
// transaction log entry layout drained by the bench.
package tv80_tb_pkg;

  localparam int ADDR_W = 16;
  localparam int DATA_W = 8;
  localparam int LOG_W  = 2 + ADDR_W + DATA_W;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_ACCESS,
    ST_HOLD
  } bus_state_e;

  typedef struct packed {
    logic              is_io;
    logic              is_wr;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } log_entry_t;

endpackage

// File: rtl/tv80_bus_log_fifo.sv
// First-word-fall-through log FIFO with a sticky overflow flag; a push into a
// full FIFO is only accepted when a pop happens in the same cycle.
module tv80_bus_log_fifo
  import tv80_tb_pkg::*;
#(
  parameter int DEPTH = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       push_i,
  input  log_entry_t data_i,
  input  logic       pop_i,
  output log_entry_t data_o,
  output logic       valid_o,
  output logic       ovf_o
);

  localparam int            PW       = $clog2(DEPTH);
  localparam logic [PW:0]   FULL_CNT = (PW+1)'(DEPTH);
  localparam logic [PW:0]   CNT_ONE  = (PW+1)'(1);
  localparam logic [PW-1:0] PTR_ONE  = PW'(1);

  log_entry_t    buf_q [DEPTH];
  logic [PW-1:0] wrPtr_q, rdPtr_q;
  logic [PW:0]   count_q, count_d;
  logic          ovf_q;
  logic          empty, full, doPop, doPush;

  assign empty  = (count_q == '0);
  assign full   = (count_q == FULL_CNT);
  assign doPop  = pop_i && !empty;
  assign doPush = push_i && (!full || doPop);

  always_comb begin
    count_d = count_q;
    if (doPush && !doPop)
      count_d = count_q + CNT_ONE;
    else if (doPop && !doPush)
      count_d = count_q - CNT_ONE;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wrPtr_q <= '0;
      rdPtr_q <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      count_q <= count_d;
      if (doPush) wrPtr_q <= wrPtr_q + PTR_ONE;
      if (doPop)  rdPtr_q <= rdPtr_q + PTR_ONE;
      if (push_i && !doPush) ovf_q <= 1'b1;
    end
  end

  // Storage is deliberately not reset; emptiness is tracked by count_q.
  always_ff @(posedge clk) begin
    if (doPush) buf_q[wrPtr_q] <= data_i;
  end

  assign data_o  = empty ? '0 : buf_q[rdPtr_q];
  assign valid_o = !empty;
  assign ovf_o   = ovf_q;

endmodule

// File: rtl/tv80_bus_responder.sv
// Memory/I-O bus model for tv80s benches with per-space wait states and a
// transaction log of every completed access.
module tv80_bus_responder
  import tv80_tb_pkg::*;
#(
  parameter int MEM_AW    = 16,
  parameter int IO_AW     = 8,
  parameter int MEM_WAIT  = 0,
  parameter int IO_WAIT   = 1,
  parameter int LOG_DEPTH = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        m1_n,
  input  logic        mreq_n,
  input  logic        iorq_n,
  input  logic        rd_n,
  input  logic        wr_n,
  input  logic        rfsh_n,
  input  logic [15:0] A,
  input  logic [7:0]  dout,
  output logic [7:0]  di,
  output logic        wait_n,
  input  logic        bd_we,
  input  logic        bd_io,
  input  logic [15:0] bd_addr,
  input  logic [7:0]  bd_wdata,
  output logic        log_valid,
  input  logic        log_ready,
  output logic [25:0] log_data,
  output logic        log_ovf
);

  localparam int         MEM_DEPTH = 1 << MEM_AW;
  localparam int         IO_DEPTH  = 1 << IO_AW;
  localparam logic [3:0] MEM_N     = 4'(MEM_WAIT);
  localparam logic [3:0] IO_N      = 4'(IO_WAIT);

  logic [7:0]  mem_q [MEM_DEPTH];
  logic [7:0]  io_q  [IO_DEPTH];

  bus_state_e  state_q;
  logic [3:0]  waitCnt_q;
  logic        isIo_q, isWr_q, waitN_q;
  logic [15:0] addr_q;
  logic [7:0]  di_q;

  logic        memSel, ioSel, accStart, startIo, busIdle;
  logic [3:0]  startWait;
  logic        rdIo;
  logic [15:0] rdAddr;
  logic [7:0]  rdData;
  logic        logPush;
  log_entry_t  logEntry, logOut;

  // Refresh and interrupt-acknowledge cycles never qualify as accesses.
  assign memSel    = !mreq_n && rfsh_n;
  assign ioSel     = !iorq_n && m1_n;
  assign accStart  = (memSel || ioSel) && (!rd_n || !wr_n);
  assign startIo   = !memSel;
  assign startWait = startIo ? IO_N : MEM_N;
  assign busIdle   = mreq_n && iorq_n;

  always_comb begin
    rdIo   = isIo_q;
    rdAddr = addr_q;
    if (state_q == ST_IDLE) begin
      rdIo   = startIo;
      rdAddr = A;
    end
  end

  assign rdData = rdIo ? io_q[rdAddr[IO_AW-1:0]] : mem_q[rdAddr[MEM_AW-1:0]];

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      waitCnt_q <= '0;
      isIo_q    <= 1'b0;
      isWr_q    <= 1'b0;
      addr_q    <= '0;
      di_q      <= '0;
      waitN_q   <= 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accStart) begin
            isIo_q <= startIo;
            isWr_q <= !wr_n;
            addr_q <= A;
            if (startWait == 4'd0) begin
              state_q <= ST_ACCESS;
              if (wr_n) di_q <= rdData;
            end else begin
              state_q   <= ST_WAIT;
              waitCnt_q <= startWait - 4'd1;
              waitN_q   <= 1'b0;
            end
          end
        end
        ST_WAIT: begin
          if (busIdle) begin
            state_q <= ST_IDLE;
            waitN_q <= 1'b1;
          end else if (waitCnt_q == 4'd0) begin
            state_q <= ST_ACCESS;
            waitN_q <= 1'b1;
            if (!isWr_q) di_q <= rdData;
          end else begin
            waitCnt_q <= waitCnt_q - 4'd1;
          end
        end
        ST_ACCESS: state_q <= ST_HOLD;
        ST_HOLD:   if (busIdle) state_q <= ST_IDLE;
        default:   state_q <= ST_IDLE;
      endcase
    end
  end

  // Arrays survive reset; the bus write is ordered last so it beats the backdoor.
  always_ff @(posedge clk) begin
    if (bd_we) begin
      if (bd_io) io_q[bd_addr[IO_AW-1:0]]   <= bd_wdata;
      else       mem_q[bd_addr[MEM_AW-1:0]] <= bd_wdata;
    end
    if (state_q == ST_ACCESS && isWr_q) begin
      if (isIo_q) io_q[addr_q[IO_AW-1:0]]   <= dout;
      else        mem_q[addr_q[MEM_AW-1:0]] <= dout;
    end
  end

  assign logPush  = (state_q == ST_ACCESS);
  assign logEntry = '{is_io: isIo_q, is_wr: isWr_q, addr: addr_q,
                      data: (isWr_q ? dout : di_q)};

  tv80_bus_log_fifo #(.DEPTH(LOG_DEPTH)) u_log (
    .clk     (clk),
    .reset   (reset),
    .push_i  (logPush),
    .data_i  (logEntry),
    .pop_i   (log_ready),
    .data_o  (logOut),
    .valid_o (log_valid),
    .ovf_o   (log_ovf)
  );

  assign di       = di_q;
  assign wait_n   = waitN_q;
  assign log_data = logOut;

endmodule
